// File: rtl/mem_pkg.sv
// +----------------------------------------------------------------------+
// | mem_pkg : command encoding, port ids and arbiter state type          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_pkg;

  localparam logic [1:0] c_cmd_none    = 2'b00;
  localparam logic [1:0] c_cmd_write   = 2'b01;
  localparam logic [1:0] c_cmd_illegal = 2'b10;
  localparam logic [1:0] c_cmd_read    = 2'b11;

  localparam logic c_port_cpu = 1'b0;
  localparam logic c_port_ldr = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_DATA = 2'd2
  } arb_state_t;

  function automatic logic is_request(input logic [1:0] cmd);
    return (cmd == c_cmd_write) || (cmd == c_cmd_read);
  endfunction

  function automatic logic is_illegal(input logic [1:0] cmd);
    return cmd == c_cmd_illegal;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// +----------------------------------------------------------------------+
// | rr_pick2 : two-way round-robin pick, the port not granted last wins  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : CPU/loader arbiter in front of a 1-cycle sync RAM      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [1:0]        ldr_cmd,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              cpu_gnt,
  output logic              ldr_gnt,
  output logic              cpu_rvalid,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cpu_wait,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_cmd
);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_winner;
  logic              r_last;
  logic [1:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_req;
  logic              w_pick;
  logic              w_pick_valid;

  // Illegal commands never count as requests, so the other port still arbitrates.
  assign w_req = {is_request(ldr_cmd), is_request(cpu_cmd)};

  rr_pick2 u_pick (
    .req    (w_req),
    .last   (r_last),
    .winner (w_pick),
    .valid  (w_pick_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_winner <= c_port_cpu;
      r_last   <= c_port_ldr;
      r_cmd    <= c_cmd_none;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_IDLE && w_pick_valid) begin
        r_winner <= w_pick;
        r_last   <= w_pick;
        r_cmd    <= w_pick ? ldr_cmd   : cpu_cmd;
        r_addr   <= w_pick ? ldr_addr  : cpu_addr;
        r_wdata  <= w_pick ? ldr_wdata : cpu_wdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (w_pick_valid) w_next_state = ST_ISSUE;
      ST_ISSUE:   w_next_state = (r_cmd == c_cmd_read) ? ST_RD_DATA : ST_IDLE;
      ST_RD_DATA: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  assign cpu_gnt    = (r_state == ST_ISSUE)   && (r_winner == c_port_cpu);
  assign ldr_gnt    = (r_state == ST_ISSUE)   && (r_winner == c_port_ldr);
  assign cpu_rvalid = (r_state == ST_RD_DATA) && (r_winner == c_port_cpu);
  assign ldr_rvalid = (r_state == ST_RD_DATA) && (r_winner == c_port_ldr);
  assign rdata      = (r_state == ST_RD_DATA) ? mem_rdata : '0;

  assign mem_cmd   = (r_state == ST_ISSUE) ? r_cmd : c_cmd_none;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign cpu_wait = is_request(cpu_cmd) && !cpu_gnt;
  assign err_cmd  = !reset && (r_state == ST_IDLE) &&
                    (is_illegal(cpu_cmd) || is_illegal(ldr_cmd));

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : timeline-model checker plus directed scenarios      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NCYC = 2048;

  logic          clk, reset;
  logic [1:0]    cpu_cmd, ldr_cmd;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_wait, err_cmd;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_cmd(ldr_cmd), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt),
    .cpu_rvalid(cpu_rvalid), .ldr_rvalid(ldr_rvalid), .rdata(rdata),
    .cpu_wait(cpu_wait),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_cmd(err_cmd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM attached to the arbiter: synchronous read, one cycle latency
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_cmd == 2'b01) ram[mem_addr] <= mem_wdata;
    if (mem_cmd == 2'b11) mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_req(input logic [1:0] c);
    return (c == 2'b01) || (c == 2'b11);
  endfunction

  // Timeline model: each arbitration schedules its grant and read return
  // directly onto future cycle slots.
  int            cyc = 0;
  int            idle_from = 0;
  int            m_last = 1;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_ram [0:(1<<AW)-1];
  int            exp_gnt [NCYC];
  int            exp_rv [NCYC];
  logic [1:0]    exp_cmd [NCYC];
  logic [DW-1:0] exp_rdata [NCYC];

  always @(posedge clk) begin
    int c, w;
    logic [1:0] cm;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    c = cyc;
    if (reset) begin
      for (int k = c + 1; k <= c + 4; k++) begin
        exp_gnt[k] = 0;
        exp_rv[k]  = 0;
      end
      idle_from = c + 1;
      m_last  = 1;
      m_addr  = '0;
      m_wdata = '0;
    end else if (c >= idle_from && (is_req(cpu_cmd) || is_req(ldr_cmd))) begin
      if (is_req(cpu_cmd) && is_req(ldr_cmd)) w = (m_last == 1) ? 0 : 1;
      else w = is_req(cpu_cmd) ? 0 : 1;
      m_last = w;
      cm = w ? ldr_cmd : cpu_cmd;
      ad = w ? ldr_addr : cpu_addr;
      wd = w ? ldr_wdata : cpu_wdata;
      m_addr  = ad;
      m_wdata = wd;
      exp_gnt[c+1] = w + 1;
      exp_cmd[c+1] = cm;
      if (cm == 2'b01) begin
        m_ram[ad] = wd;
        idle_from = c + 2;
      end else begin
        exp_rv[c+2]    = w + 1;
        exp_rdata[c+2] = m_ram[ad];
        idle_from = c + 3;
      end
    end
    cyc = c + 1;
  end

  int err_seen = 0;
  int ldr_gnt_seen = 0;
  int cpu_rv_seen = 0;

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    int g, v;
    bit idle;
    if (err_cmd) err_seen++;
    if (ldr_gnt) ldr_gnt_seen++;
    if (cpu_rvalid) cpu_rv_seen++;
    chk("one_gnt", 32'(cpu_gnt & ldr_gnt), 32'd0);
    chk("one_rvalid", 32'(cpu_rvalid & ldr_rvalid), 32'd0);
    if (reset) begin
      chk("rst_gnt", {cpu_gnt, ldr_gnt}, 32'd0);
      chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_mem_cmd", 32'(mem_cmd), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_err", 32'(err_cmd), 32'd0);
    end else begin
      g = exp_gnt[cyc];
      v = exp_rv[cyc];
      idle = (cyc >= idle_from);
      chk("cpu_gnt", 32'(cpu_gnt), 32'(g == 1));
      chk("ldr_gnt", 32'(ldr_gnt), 32'(g == 2));
      chk("mem_cmd", 32'(mem_cmd), (g != 0) ? 32'(exp_cmd[cyc]) : 32'd0);
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(v == 1));
      chk("ldr_rvalid", 32'(ldr_rvalid), 32'(v == 2));
      chk("rdata", 32'(rdata), (v != 0) ? 32'(exp_rdata[cyc]) : 32'd0);
      chk("cpu_wait", 32'(cpu_wait), 32'(is_req(cpu_cmd) && g != 1));
      chk("err_cmd", 32'(err_cmd),
          32'(idle && (cpu_cmd == 2'b10 || ldr_cmd == 2'b10)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cpu_xfer(input logic [1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int gcyc);
    int n = 0;
    cpu_cmd = c; cpu_addr = a; cpu_wdata = d;
    do begin @(negedge clk); n++; end while (!cpu_gnt && n < 40);
    gcyc = cyc;
    if (!cpu_gnt) chk("cpu_gnt_timeout", 32'd0, 32'd1);
    tick();
    cpu_cmd = 2'b00;
  endtask

  task automatic ldr_xfer(input logic [1:0] c, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int gcyc);
    int n = 0;
    ldr_cmd = c; ldr_addr = a; ldr_wdata = d;
    do begin @(negedge clk); n++; end while (!ldr_gnt && n < 40);
    gcyc = cyc;
    if (!ldr_gnt) chk("ldr_gnt_timeout", 32'd0, 32'd1);
    tick();
    ldr_cmd = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cg, lg, e0, l0, r0, ng;
    int seq [8];
    reset = 1'b1;
    cpu_cmd = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    ldr_cmd = 2'b00; ldr_addr = '0; ldr_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]   = '0;
      m_ram[i] = '0;
    end
    ram[5]   = 16'hABCD;
    m_ram[5] = 16'hABCD;

    // Reset values
    @(negedge clk);
    chk("reset_mem_cmd", 32'(mem_cmd), 32'd0);
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_rdata", 32'(rdata), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // CPU read of address 5
    cpu_cmd = 2'b11; cpu_addr = 9'h005;
    @(negedge clk);
    chk("rd_idle_gnt", 32'(cpu_gnt), 32'd0);
    @(negedge clk);
    chk("rd_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_mem_cmd", 32'(mem_cmd), 32'h3);
    chk("rd_mem_addr", 32'(mem_addr), 32'h005);
    tick();
    cpu_cmd = 2'b00;
    @(negedge clk);
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata", 32'(rdata), 32'hABCD);
    tick();

    // Both write after reset: CPU first, loader two cycles later
    do_reset();
    fork
      cpu_xfer(2'b01, 9'h010, 16'h1111, cg);
      ldr_xfer(2'b01, 9'h020, 16'h2222, lg);
    join
    chk("tie_cpu_first", 32'(lg - cg), 32'd2);
    tick(); tick();
    chk("ram_10", 32'(ram[9'h010]), 32'h1111);
    chk("ram_20", 32'(ram[9'h020]), 32'h2222);

    // Continuous contention: 8 alternating grants starting with the CPU
    do_reset();
    cpu_cmd = 2'b01; cpu_addr = 9'h030; cpu_wdata = 16'h3030;
    ldr_cmd = 2'b01; ldr_addr = 9'h031; ldr_wdata = 16'h3131;
    ng = 0;
    for (int i = 0; i < 60 && ng < 8; i++) begin
      @(negedge clk);
      if (cpu_gnt) begin seq[ng] = 0; ng++; end
      else if (ldr_gnt) begin seq[ng] = 1; ng++; end
    end
    chk("rr_count", 32'(ng), 32'd8);
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(seq[i]), 32'(i % 2));
    tick();
    cpu_cmd = 2'b00; ldr_cmd = 2'b00;
    tick(); tick(); tick();

    // Illegal loader command alongside a CPU write
    e0 = err_seen; l0 = ldr_gnt_seen;
    cpu_cmd = 2'b01; cpu_addr = 9'h040; cpu_wdata = 16'h4444;
    ldr_cmd = 2'b10;
    @(negedge clk);
    chk("illegal_err", 32'(err_cmd), 32'd1);
    tick();
    ldr_cmd = 2'b00;
    @(negedge clk);
    chk("illegal_cpu_gnt", 32'(cpu_gnt), 32'd1);
    tick();
    cpu_cmd = 2'b00;
    tick(); tick();
    chk("illegal_err_once", 32'(err_seen - e0), 32'd1);
    chk("illegal_no_ldr_gnt", 32'(ldr_gnt_seen - l0), 32'd0);
    chk("ram_40", 32'(ram[9'h040]), 32'h4444);

    // CPU read held while the loader read is in flight
    ldr_cmd = 2'b11; ldr_addr = 9'h040;
    tick();
    cpu_cmd = 2'b11; cpu_addr = 9'h010;
    @(negedge clk);
    chk("hold_ldr_gnt", 32'(ldr_gnt), 32'd1);
    chk("hold_wait_issue", 32'(cpu_wait), 32'd1);
    tick();
    ldr_cmd = 2'b00;
    @(negedge clk);
    chk("hold_ldr_rdata", 32'(rdata), 32'h4444);
    chk("hold_wait_rd", 32'(cpu_wait), 32'd1);
    tick();
    @(negedge clk);
    chk("hold_wait_idle", 32'(cpu_wait), 32'd1);
    tick();
    @(negedge clk);
    chk("hold_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("hold_wait_gnt", 32'(cpu_wait), 32'd0);
    tick();
    cpu_cmd = 2'b00;
    @(negedge clk);
    chk("hold_cpu_rdata", 32'(rdata), 32'h1111);
    tick(); tick();

    // Reset in the middle of a CPU read's data cycle
    cpu_cmd = 2'b11; cpu_addr = 9'h005;
    tick();
    tick();
    cpu_cmd = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("abort_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    tick(); tick();
    reset = 1'b0;
    r0 = cpu_rv_seen;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_no_rvalid", 32'(cpu_rv_seen - r0), 32'd0);
    cpu_xfer(2'b11, 9'h005, 16'h0000, cg);
    @(negedge clk);
    chk("after_abort_rdata", 32'(rdata), 32'hABCD);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
